reaction_stim: RTL and testbench

- Stimulus generator directly upstream of the reaction-time comparator.
- On a start request it waits a pseudo-random delay with all target LEDs dark. It then lights one randomly chosen target, driving a one-hot `bit_sel`.
- In the same cycle it issues the single-cycle `det_start` that begins timing. It then waits for the comparator's `det_end`.
- It detects a premature button press (foul) and honours `restart` from any state.

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/reaction_stim_if.sv | 24 ++
 rtl/reaction_stim_lfsr16.sv | 29 ++
 rtl/reaction_stim.sv | 129 ++++++++++++
 tb/tb_reaction_stim.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game: stimulus FSM states, LFSR taps
// and the ms tick rate that the stimulus generator and the comparator must agree on.
`timescale 1ns/1ps
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DLY = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DONE     = 3'd3,
    ST_FOUL     = 3'd4
  } state_t;

  localparam int          DEFAULT_CLK_PER_MS = 12000;
  localparam logic [15:0] LFSR_TAPS          = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED  = 16'hACE1;
  localparam logic [7:0]  BTN_NONE           = 8'hFF;

  // Fibonacci step, taps 16,14,13,11: the parity of the tapped bits shifts in at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_stim_if.sv
// Handshake bundle between the stimulus generator, the button/start front end
// and the reaction-time comparator.
`timescale 1ns/1ps
interface reaction_stim_if;
  logic       start;
  logic       restart;
  logic [7:0] btn_deb;
  logic       det_end;
  logic [7:0] bit_sel;
  logic       det_start;
  logic       busy;
  logic       foul;
  logic       done;

  modport slave (
    input  start, restart, btn_deb, det_end,
    output bit_sel, det_start, busy, foul, done
  );

  modport master (
    output start, restart, btn_deb, det_end,
    input  bit_sel, det_start, busy, foul, done
  );
endinterface

// File: rtl/reaction_stim_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; its value at the moment of a start request
// supplies the random delay and target.
`timescale 1ns/1ps
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;

  // The all-zero lock-up state is unreachable from a non-zero seed; reload defensively anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (r_lfsr == 16'h0000) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/reaction_stim.sv
// Reaction-game stimulus generator: random dark delay, then one lit target plus a
// det_start pulse to the comparator; catches early presses as fouls.
`timescale 1ns/1ps
module reaction_stim
  import reaction_pkg::*;
#(
  parameter int          CLK_PER_MS = DEFAULT_CLK_PER_MS,
  parameter int          MIN_DLY_MS = 1000,
  parameter int          RAND_BITS  = 11,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  reaction_stim_if.slave  bus
);

  localparam int DLY_MAX = MIN_DLY_MS + (2 ** RAND_BITS) - 1;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
  localparam int PRE_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [15:0]      w_lfsr;
  logic             w_tick;
  logic             w_press;
  logic [DLY_W-1:0] w_dly_seed;

  state_t           r_state;
  logic [DLY_W-1:0] r_dly;
  logic [PRE_W-1:0] r_presc;
  logic [2:0]       r_tgt;
  logic [7:0]       r_bit_sel;
  logic             r_det_start;
  logic             r_busy;
  logic             r_foul;
  logic             r_done;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  assign w_tick     = (r_presc == PRE_W'(CLK_PER_MS - 1));
  assign w_press    = (bus.btn_deb != BTN_NONE);
  assign w_dly_seed = DLY_W'(MIN_DLY_MS) + DLY_W'(w_lfsr[RAND_BITS-1:0]);

  // restart outranks everything; within WAIT_DLY a press outranks the ms tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dly       <= '0;
      r_presc     <= '0;
      r_tgt       <= '0;
      r_bit_sel   <= '0;
      r_det_start <= 1'b0;
      r_busy      <= 1'b0;
      r_foul      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_det_start <= 1'b0;
      if (bus.restart) begin
        r_state   <= ST_IDLE;
        r_presc   <= '0;
        r_bit_sel <= '0;
        r_busy    <= 1'b0;
        r_foul    <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_FOUL: begin
            if (bus.start) begin
              r_state   <= ST_WAIT_DLY;
              r_dly     <= w_dly_seed;
              r_tgt     <= w_lfsr[15:13];
              r_presc   <= '0;
              r_bit_sel <= '0;
              r_busy    <= 1'b1;
              r_foul    <= 1'b0;
              r_done    <= 1'b0;
            end
          end
          ST_WAIT_DLY: begin
            if (w_press) begin
              r_state   <= ST_FOUL;
              r_bit_sel <= '0;
              r_busy    <= 1'b0;
              r_foul    <= 1'b1;
            end else if (w_tick) begin
              r_presc <= '0;
              // The last ms of the delay ends on this edge: light the target and start timing together.
              if (r_dly <= DLY_W'(1)) begin
                r_state     <= ST_ARMED;
                r_dly       <= '0;
                r_bit_sel   <= 8'd1 << r_tgt;
                r_det_start <= 1'b1;
              end else begin
                r_dly <= r_dly - DLY_W'(1);
              end
            end else begin
              r_presc <= r_presc + PRE_W'(1);
            end
          end
          ST_ARMED: begin
            if (bus.det_end) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_bit_sel <= '0;
            r_busy    <= 1'b0;
            r_foul    <= 1'b0;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bit_sel   = r_bit_sel;
  assign bus.det_start = r_det_start;
  assign bus.busy      = r_busy;
  assign bus.foul      = r_foul;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_reaction_stim.sv
// Self-checking bench for reaction_stim: a behavioural LFSR model predicts each
// round's delay (whole ms * ticks) and target, and randomized rounds are scored against it.
`timescale 1ns/1ps
module tb_reaction_stim;

  localparam int          CPM     = 4;
  localparam int          MIN_DLY = 2;
  localparam int          RB      = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] mLfsr;

  always #5 clk = ~clk;

  reaction_stim_if bus();

  reaction_stim #(
    .CLK_PER_MS (CPM),
    .MIN_DLY_MS (MIN_DLY),
    .RAND_BITS  (RB),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference sequence generator: x^16+x^14+x^13+x^11 written as explicit bit XORs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mLfsr <= SEED;
    else        mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  function automatic int expCycles(input logic [15:0] l);
    logic [RB-1:0] r;
    r = l[RB-1:0];
    return (MIN_DLY + int'(r)) * CPM;
  endfunction

  function automatic logic [7:0] expSel(input logic [15:0] l);
    logic [2:0] t;
    t = l[15:13];
    return 8'(1 << t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulseRestart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
  endtask

  task automatic waitArm(input int limit, output int n, output logic [7:0] sel);
    n = 0;
    sel = 8'h00;
    while (n < limit) begin
      step();
      n++;
      if (bus.det_start === 1'b1) begin
        sel = bus.bit_sel;
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.restart = 1'b0; bus.det_end = 1'b0; bus.btn_deb = 8'hFF;
    rst_n = 1'b0;
    #23;
    checks++; if (bus.bit_sel !== 8'h00) begin failures++; $display("[TB] FAIL reset_bit_sel got=%h exp=00", bus.bit_sel); end
    checks++; if ({bus.det_start, bus.busy, bus.foul, bus.done} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {bus.det_start, bus.busy, bus.foul, bus.done}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    checks++; if ({bus.busy, bus.bit_sel} !== 9'h000) begin failures++; $display("[TB] FAIL idle_after_reset got=%h exp=000", {bus.busy, bus.bit_sel}); end
  endtask

  // Wait for a model state with rand=01 and target=5, so the round is 3 ms = 12 cycles on LED 5.
  task automatic test_targeted_round();
    int k = 0;
    int n;
    logic [7:0] sel;
    bit found = 0;
    while (!found && k < 4000) begin
      if (mLfsr[1:0] == 2'b01 && mLfsr[15:13] == 3'd5) found = 1;
      else begin step(); k++; end
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL seed_search got=%0d exp<4000", k); end
    pulseStart();
    checks++; if ({bus.busy, bus.bit_sel, bus.det_start} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("[TB] FAIL wait_entry got=%b/%h/%b exp=1/00/0", bus.busy, bus.bit_sel, bus.det_start); end
    waitArm(64, n, sel);
    checks++; if (n !== 12) begin failures++; $display("[TB] FAIL arm_latency got=%0d exp=12", n); end
    checks++; if (sel !== 8'h20) begin failures++; $display("[TB] FAIL arm_bit_sel got=%h exp=20", sel); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL armed_busy got=%b exp=1", bus.busy); end
    step();
    checks++; if ({bus.det_start, bus.bit_sel} !== {1'b0, 8'h20}) begin failures++; $display("[TB] FAIL det_start_single got=%b/%h exp=0/20", bus.det_start, bus.bit_sel); end
  endtask

  task automatic test_det_end();
    int hold = $urandom_range(1, 6);
    int bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.bit_sel !== 8'h20 || bus.det_start !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL armed_hold got=%0d exp=0 bad cycles", bad); end
    bus.det_end = 1'b1; step(); bus.det_end = 1'b0;
    checks++; if ({bus.done, bus.busy, bus.bit_sel} !== {1'b1, 1'b0, 8'h20}) begin failures++; $display("[TB] FAIL det_end_done got=%b/%b/%h exp=1/0/20", bus.done, bus.busy, bus.bit_sel); end
    bus.det_end = 1'b1; step(); bus.det_end = 1'b0;
    checks++; if ({bus.done, bus.busy, bus.bit_sel, bus.det_start} !== {1'b1, 1'b0, 8'h20, 1'b0}) begin failures++; $display("[TB] FAIL second_det_end got=%b/%b/%h/%b exp=1/0/20/0", bus.done, bus.busy, bus.bit_sel, bus.det_start); end
  endtask

  task automatic test_foul();
    logic [15:0] rec;
    int pulses = 0;
    int n;
    logic [7:0] sel;
    pulseStart();
    repeat (4) step();
    bus.btn_deb = 8'hFB; step(); bus.btn_deb = 8'hFF;
    checks++; if ({bus.foul, bus.busy, bus.done, bus.bit_sel} !== {3'b100, 8'h00}) begin failures++; $display("[TB] FAIL foul_entry got=%b%b%b/%h exp=100/00", bus.foul, bus.busy, bus.done, bus.bit_sel); end
    for (int i = 0; i < 40; i++) begin step(); if (bus.det_start === 1'b1) pulses++; end
    checks++; if (pulses != 0 || bus.foul !== 1'b1) begin failures++; $display("[TB] FAIL foul_hold got=%0d/%b exp=0/1", pulses, bus.foul); end
    rec = mLfsr;
    pulseStart();
    checks++; if ({bus.foul, bus.busy} !== 2'b01) begin failures++; $display("[TB] FAIL foul_restart got=%b%b exp=01", bus.foul, bus.busy); end
    waitArm(64, n, sel);
    checks++; if (n !== expCycles(rec) || sel !== expSel(rec)) begin failures++; $display("[TB] FAIL post_foul_round got=%0d/%h exp=%0d/%h", n, sel, expCycles(rec), expSel(rec)); end
    pulseRestart();
    checks++; if ({bus.busy, bus.bit_sel} !== 9'h000) begin failures++; $display("[TB] FAIL restart_armed got=%h exp=000", {bus.busy, bus.bit_sel}); end
  endtask

  task automatic test_restart_on_tick();
    logic [15:0] rec;
    int e;
    int pulses = 0;
    rec = mLfsr;
    e = expCycles(rec);
    pulseStart();
    for (int i = 1; i < e; i++) begin step(); if (bus.det_start === 1'b1) pulses++; end
    bus.restart = 1'b1; step(); bus.restart = 1'b0;
    checks++; if ({bus.det_start, bus.busy, bus.foul, bus.done, bus.bit_sel} !== 12'h000) begin failures++; $display("[TB] FAIL restart_on_tick got=%b%b%b%b/%h exp=0000/00", bus.det_start, bus.busy, bus.foul, bus.done, bus.bit_sel); end
    for (int i = 0; i < 30; i++) begin step(); if (bus.det_start === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL restart_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_ignored_start();
    logic [15:0] rec;
    int e;
    int n = -1;
    logic [7:0] sel = 8'h00;
    int bad = 0;
    rec = mLfsr;
    e = expCycles(rec);
    pulseStart();
    for (int i = 1; i <= 64 && n < 0; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      step();
      if (bus.det_start === 1'b1) begin n = i; sel = bus.bit_sel; end
    end
    checks++; if (n !== e || sel !== expSel(rec)) begin failures++; $display("[TB] FAIL start_ignored_wait got=%0d/%h exp=%0d/%h", n, sel, e, expSel(rec)); end
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      step();
      if (bus.det_start !== 1'b0 || bus.busy !== 1'b1 || bus.bit_sel !== expSel(rec)) bad++;
    end
    bus.start = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL start_ignored_armed got=%0d exp=0 bad cycles", bad); end
    pulseRestart();
  endtask

  task automatic test_random_rounds();
    logic [15:0] rec;
    int n;
    logic [7:0] sel;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 20)) step();
      rec = mLfsr;
      pulseStart();
      waitArm(64, n, sel);
      checks++; if (n !== expCycles(rec) || sel !== expSel(rec)) begin failures++; $display("[TB] FAIL rand_round%0d got=%0d/%h exp=%0d/%h", r, n, sel, expCycles(rec), expSel(rec)); end
      repeat ($urandom_range(0, 8)) step();
      bus.det_end = 1'b1; step(); bus.det_end = 1'b0;
      checks++; if ({bus.done, bus.busy, bus.bit_sel} !== {2'b10, expSel(rec)}) begin failures++; $display("[TB] FAIL rand_done%0d got=%b%b/%h exp=10/%h", r, bus.done, bus.busy, bus.bit_sel, expSel(rec)); end
    end
    pulseRestart();
  endtask

  task automatic test_async_reset();
    logic [15:0] rec;
    int pulses = 0;
    int n;
    logic [7:0] sel;
    pulseStart();
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.det_start, bus.busy, bus.foul, bus.done, bus.bit_sel} !== 12'h000) begin failures++; $display("[TB] FAIL async_reset_outputs got=%b%b%b%b/%h exp=0000/00", bus.det_start, bus.busy, bus.foul, bus.done, bus.bit_sel); end
    checks++; if (dut.u_lfsr.r_lfsr !== SEED) begin failures++; $display("[TB] FAIL async_reset_lfsr got=%h exp=%h", dut.u_lfsr.r_lfsr, SEED); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); if (bus.det_start === 1'b1 || bus.busy === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL post_reset_quiet got=%0d exp=0", pulses); end
    rec = mLfsr;
    pulseStart();
    waitArm(64, n, sel);
    checks++; if (n !== expCycles(rec) || sel !== expSel(rec)) begin failures++; $display("[TB] FAIL post_reset_round got=%0d/%h exp=%0d/%h", n, sel, expCycles(rec), expSel(rec)); end
    pulseRestart();
  endtask

  initial begin
    test_reset();
    test_targeted_round();
    test_det_end();
    test_foul();
    test_restart_on_tick();
    test_ignored_start();
    test_random_rounds();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
